rs_rx_indication: RTL

Parametrised receive-side reconciliation block for the GMII path. Every rx_clk it classifies rx_dv/rx_er/rxd into a 3-bit data_indication code. A frame FSM strips the preamble and SFD, delivers payload octets with data_valid, counts frame length, enforces a maximum length and reports per-frame completion and error status. It sits between the PCS receive output and the MAC receive interface, and replaces the fixed single-purpose indication decoder.

---
 rtl/rs_rx_indication_if.sv | 24 ++
 rtl/rs_rx_indication.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rs_rx_indication_if.sv
// GMII receive bundle between the PCS receive output (master) and the reconciliation block (slave).
interface rs_rx_indication_if #(
  parameter int unsigned LEN_W = 11
) ();
  logic [7:0]       rxd;
  logic             rx_dv;
  logic             rx_er;
  logic [2:0]       data_indication;
  logic             data_valid;
  logic [7:0]       data_out;
  logic             frame_done;
  logic             frame_err;
  logic [LEN_W-1:0] frame_len;

  modport master (
    output rxd, rx_dv, rx_er,
    input  data_indication, data_valid, data_out, frame_done, frame_err, frame_len
  );

  modport slave (
    input  rxd, rx_dv, rx_er,
    output data_indication, data_valid, data_out, frame_done, frame_err, frame_len
  );
endinterface

// File: rtl/rs_rx_indication.sv
// GMII receive reconciliation: indication decode, preamble/SFD strip, payload delivery and
// per-frame status. Define RS_CARRIER_EXT_EN to enable carrier extension (EXTEND state, codes 3/4).
module rs_rx_indication #(
  parameter int unsigned MIN_PREAMBLE = 1,
  parameter int unsigned MAX_LEN      = 1518,
  parameter int unsigned LEN_W        = 11
) (
  input logic               rx_clk,
  input logic               reset_L,
  rs_rx_indication_if.slave bus
);

  localparam logic [2:0] IndIdle          = 3'd0;
  localparam logic [2:0] IndData          = 3'd1;
  localparam logic [2:0] IndDataErr       = 3'd2;
`ifdef RS_CARRIER_EXT_EN
  localparam logic [2:0] IndCarrierExt    = 3'd3;
  localparam logic [2:0] IndCarrierExtErr = 3'd4;
`endif
  localparam logic [2:0] IndFalseCarrier  = 3'd5;
  localparam logic [2:0] IndReserved      = 3'd6;

  localparam logic [7:0] OctPre    = 8'h55;
  localparam logic [7:0] OctSfd    = 8'hD5;
  localparam logic [7:0] OctExt    = 8'h0F;
  localparam logic [7:0] OctExtErr = 8'h1F;
  localparam logic [7:0] OctFalse  = 8'h0E;

  localparam logic [2:0]       MinPre  = 3'(MIN_PREAMBLE);
  localparam logic [LEN_W-1:0] LenMax  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LenOver = LEN_W'(MAX_LEN + 1);

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StData,
`ifdef RS_CARRIER_EXT_EN
    StExtend,
`endif
    StDrop
  } state_e;

  state_e           state_q;
  logic [2:0]       pre_cnt_q;
  logic [LEN_W-1:0] len_q;
  logic             err_q;
  logic [2:0]       ind_q;
  logic [2:0]       ind_d;
  logic             data_valid_q;
  logic [7:0]       data_out_q;
  logic             frame_done_q;
  logic             frame_err_q;
  logic [LEN_W-1:0] frame_len_q;

  logic is_pre;
  logic is_idle_in;
`ifdef RS_CARRIER_EXT_EN
  logic is_ext;
  logic is_ext_err;
`endif

  // Burst continuation and IDLE entry both key on a 0x55 with dv high, independent of er.
  assign is_pre     = bus.rx_dv && (bus.rxd == OctPre);
  assign is_idle_in = !bus.rx_dv && !bus.rx_er;
`ifdef RS_CARRIER_EXT_EN
  assign is_ext     = !bus.rx_dv && bus.rx_er && (bus.rxd == OctExt);
  assign is_ext_err = !bus.rx_dv && bus.rx_er && (bus.rxd == OctExtErr);
`endif

  always_comb begin
    ind_d = IndReserved;
    if (is_idle_in) begin
      ind_d = IndIdle;
    end else if (bus.rx_dv) begin
      ind_d = bus.rx_er ? IndDataErr : IndData;
    end else if (bus.rxd == OctFalse) begin
      ind_d = IndFalseCarrier;
    end
`ifdef RS_CARRIER_EXT_EN
    else if (bus.rxd == OctExt) begin
      ind_d = IndCarrierExt;
    end else if (bus.rxd == OctExtErr) begin
      ind_d = IndCarrierExtErr;
    end
`endif
  end

  always_ff @(posedge rx_clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q      <= StIdle;
      pre_cnt_q    <= '0;
      len_q        <= '0;
      err_q        <= 1'b0;
      ind_q        <= IndIdle;
      data_valid_q <= 1'b0;
      data_out_q   <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      frame_len_q  <= '0;
    end else begin
      ind_q        <= ind_d;
      data_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (is_pre) begin
            state_q   <= StPreamble;
            pre_cnt_q <= 3'd1;
          end else if (bus.rx_dv) begin
            state_q <= StDrop;
            err_q   <= 1'b1;
            len_q   <= '0;
          end
        end
        StPreamble: begin
          if (!bus.rx_dv) begin
            state_q      <= StIdle;
            frame_done_q <= 1'b1;
            frame_err_q  <= 1'b1;
            frame_len_q  <= '0;
          end else if (!bus.rx_er && bus.rxd == OctPre) begin
            if (pre_cnt_q != 3'd7) pre_cnt_q <= pre_cnt_q + 3'd1;
          end else if (!bus.rx_er && bus.rxd == OctSfd && pre_cnt_q >= MinPre) begin
            state_q <= StData;
            len_q   <= '0;
            err_q   <= 1'b0;
          end else begin
            state_q <= StDrop;
            err_q   <= 1'b1;
            len_q   <= '0;
          end
        end
        StData: begin
          if (bus.rx_dv) begin
            if (len_q == LenMax) begin
              // Overlong: swallow the rest, report MAX_LEN+1 when the drop ends.
              state_q <= StDrop;
              err_q   <= 1'b1;
              len_q   <= LenOver;
            end else begin
              data_valid_q <= 1'b1;
              data_out_q   <= bus.rxd;
              len_q        <= len_q + 1'b1;
              if (bus.rx_er) err_q <= 1'b1;
            end
          end
`ifdef RS_CARRIER_EXT_EN
          else if (is_ext) begin
            state_q <= StExtend;
          end
`endif
          else begin
            state_q      <= StIdle;
            frame_done_q <= 1'b1;
            frame_err_q  <= err_q;
            frame_len_q  <= len_q;
          end
        end
`ifdef RS_CARRIER_EXT_EN
        StExtend: begin
          if (is_ext_err) begin
            err_q <= 1'b1;
          end else if (!is_ext) begin
            frame_done_q <= 1'b1;
            frame_err_q  <= err_q;
            frame_len_q  <= len_q;
            if (is_pre) begin
              state_q   <= StPreamble;
              pre_cnt_q <= 3'd1;
            end else begin
              state_q <= StIdle;
            end
          end
        end
`endif
        StDrop: begin
          if (is_idle_in) begin
            state_q      <= StIdle;
            frame_done_q <= 1'b1;
            frame_err_q  <= 1'b1;
            frame_len_q  <= len_q;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.data_indication = ind_q;
  assign bus.data_valid      = data_valid_q;
  assign bus.data_out        = data_out_q;
  assign bus.frame_done      = frame_done_q;
  assign bus.frame_err       = frame_err_q;
  assign bus.frame_len       = frame_len_q;

endmodule
